// File: rtl/lane_result_serializer_if.sv
// Stream bundle for the lane serializer: 36-bit word in, one tagged 12-bit lane out.
// slave = serializer side, master = producer/consumer side.
interface lane_result_serializer_if #(
  parameter int LANE_W    = 12,
  parameter int NUM_LANES = 3,
  parameter int CNT_W     = 16
);
  localparam int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [LANE_W*NUM_LANES-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANE_W-1:0]           out_data;
  logic [LANE_IDX_W-1:0]       out_lane;
  logic                        out_last;
  logic                        out_parity;
  logic [CNT_W-1:0]            word_count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, out_parity, word_count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, out_parity, word_count
  );
endinterface

// File: rtl/lane_result_serializer.sv
// Registers a multi-lane result word and emits it lowest lane first, one lane per
// cycle, tagged with lane index, last flag and even parity; counts completed words.
module lane_result_serializer #(
  parameter int LANE_W    = 12,
  parameter int NUM_LANES = 3,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  lane_result_serializer_if.slave   bus
);
  localparam int DATA_W     = LANE_W * NUM_LANES;
  localparam int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int LANE_SLOTS = 1 << LANE_IDX_W;
  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(NUM_LANES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [DATA_W-1:0]     hold_reg;
  logic [LANE_IDX_W-1:0] lane_reg;
  logic [LANE_W-1:0]     out_data_reg;
  logic [LANE_IDX_W-1:0] out_lane_reg;
  logic                  out_last_reg;
  logic                  out_parity_reg;
  logic [CNT_W-1:0]      word_count_reg;

  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  in_hs;
  logic                  out_hs;
  logic                  last_lane;
  logic [LANE_IDX_W-1:0] lane_inc;
  logic [LANE_W-1:0]     lane_slot [LANE_SLOTS];

  // Unused slots (index >= NUM_LANES) read as zero; they are never selected.
  for (genvar gi = 0; gi < LANE_SLOTS; gi++) begin : g_lane_slot
    if (gi < NUM_LANES) begin : g_real
      assign lane_slot[gi] = hold_reg[gi*LANE_W +: LANE_W];
    end else begin : g_pad
      assign lane_slot[gi] = '0;
    end
  end

  assign last_lane = (lane_reg == LAST_LANE);
  assign lane_inc  = lane_reg + 1'b1;
  assign in_hs     = bus.in_valid && in_ready_c;
  assign out_hs    = out_valid_c && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_hs) state_next = SEND;
      end
      SEND: begin
        // A new word captured on the final lane keeps us in SEND with no bubble.
        if (out_hs && last_lane && !in_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    if (rst_n) begin
      case (state_reg)
        IDLE: in_ready_c = 1'b1;
        SEND: begin
          out_valid_c = 1'b1;
          in_ready_c  = last_lane && bus.out_ready;
        end
        default: begin
          in_ready_c  = 1'b0;
          out_valid_c = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg       <= '0;
      lane_reg       <= '0;
      out_data_reg   <= '0;
      out_lane_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_parity_reg <= 1'b0;
    end else if (in_hs) begin
      hold_reg       <= bus.in_data;
      lane_reg       <= '0;
      out_data_reg   <= bus.in_data[LANE_W-1:0];
      out_lane_reg   <= '0;
      out_last_reg   <= (LAST_LANE == '0);
      out_parity_reg <= ^bus.in_data[LANE_W-1:0];
    end else if (out_hs && !last_lane) begin
      lane_reg       <= lane_inc;
      out_data_reg   <= lane_slot[lane_inc];
      out_lane_reg   <= lane_inc;
      out_last_reg   <= (lane_inc == LAST_LANE);
      out_parity_reg <= ^lane_slot[lane_inc];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_reg <= '0;
    end else if (out_hs && last_lane) begin
      word_count_reg <= word_count_reg + 1'b1;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = out_data_reg;
  assign bus.out_lane   = out_lane_reg;
  assign bus.out_last   = out_last_reg;
  assign bus.out_parity = out_parity_reg;
  assign bus.word_count = word_count_reg;
endmodule

// File: tb/tb_lane_result_serializer.sv
// Directed + random bench: a queue of pending lanes models the serializer; a second
// instance with a 4-bit counter exercises the word_count wrap.
module tb_lane_result_serializer;
  localparam int LANE_W    = 12;
  localparam int NUM_LANES = 3;
  localparam int CNT_W     = 16;
  localparam int CNT_W_S   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lane_result_serializer_if #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .CNT_W(CNT_W))   ifa ();
  lane_result_serializer_if #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .CNT_W(CNT_W_S)) ifw ();

  assign ifw.in_valid  = ifa.in_valid;
  assign ifw.in_data   = ifa.in_data;
  assign ifw.out_ready = ifa.out_ready;

  lane_result_serializer #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  lane_result_serializer #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .CNT_W(CNT_W_S)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifw.slave)
  );

  typedef struct {
    logic [11:0] data;
    int          lane;
  } beat_t;

  beat_t q[$];
  int    cnt      = 0;
  int    checks   = 0;
  int    failures = 0;
  int    ir_seen  = 0;
  int    ov_seen  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the lane queue, then advance the model.
  task automatic cycle(input logic iv, input logic [35:0] id, input logic ordy);
    logic  exp_ir;
    beat_t b;
    @(negedge clk);
    ifa.in_valid  = iv;
    ifa.in_data   = id;
    ifa.out_ready = ordy;
    #1;
    exp_ir = (q.size() == 0) || (q.size() == 1 && ordy);
    check("out_valid", ifa.out_valid, q.size() != 0);
    check("in_ready", ifa.in_ready, exp_ir);
    check("word_count", ifa.word_count, cnt % 65536);
    check("wrap_count", ifw.word_count, cnt % 16);
    if (ifa.in_ready === 1'b1) ir_seen++;
    if (ifa.out_valid === 1'b1) ov_seen++;
    if (q.size() != 0) begin
      check("out_data", ifa.out_data, q[0].data);
      check("out_lane", ifa.out_lane, q[0].lane);
      check("out_last", ifa.out_last, q[0].lane == NUM_LANES - 1);
      check("out_parity", ifa.out_parity, ^q[0].data);
      check("wrap_out_data", ifw.out_data, q[0].data);
    end
    if (q.size() != 0 && ordy) begin
      b = q.pop_front();
      if (b.lane == NUM_LANES - 1) cnt++;
    end
    if (iv && exp_ir) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        b.data = id[k*LANE_W +: LANE_W];
        b.lane = k;
        q.push_back(b);
      end
    end
    @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, ifa.out_valid, 1'b0);
    check({tag, "_in_ready"}, ifa.in_ready, 1'b0);
    check({tag, "_out_data"}, ifa.out_data, 12'h000);
    check({tag, "_out_lane"}, ifa.out_lane, 2'd0);
    check({tag, "_out_last"}, ifa.out_last, 1'b0);
    check({tag, "_out_parity"}, ifa.out_parity, 1'b0);
    check({tag, "_word_count"}, ifa.word_count, 16'h0000);
  endtask

  logic [35:0] words [4];
  logic [35:0] rnd;

  initial begin
    ifa.in_valid  = 1'b0;
    ifa.in_data   = '0;
    ifa.out_ready = 1'b0;
    words[0] = 36'hAAA_BBB_CCC;
    words[1] = 36'h000_FFF_001;
    words[2] = 36'h5A5_A5A_5A5;
    words[3] = 36'hFFF_FFF_FFF;

    // Power-on reset, asserted asynchronously before any clock edge
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word
    cycle(1'b1, 36'h123_456_789, 1'b1);
    #1;
    check("single_lane0_data", ifa.out_data, 12'h789);
    check("single_lane0_parity", ifa.out_parity, 1'b0);
    cycle(1'b0, 36'h0, 1'b1);
    #1;
    check("single_lane1_data", ifa.out_data, 12'h456);
    check("single_lane1_parity", ifa.out_parity, 1'b1);
    cycle(1'b0, 36'h0, 1'b1);
    #1;
    check("single_lane2_data", ifa.out_data, 12'h123);
    check("single_lane2_last", ifa.out_last, 1'b1);
    cycle(1'b0, 36'h0, 1'b1);
    #1;
    check("single_count", ifa.word_count, 16'd1);
    check("single_idle", ifa.out_valid, 1'b0);
    cycle(1'b0, 36'h0, 1'b1);

    // Back-to-back words, in_valid held high
    cycle(1'b1, words[0], 1'b1);
    ir_seen = 0;
    ov_seen = 0;
    for (int beat = 0; beat < 12; beat++) begin
      if (beat / 3 + 1 < 4) cycle(1'b1, words[beat/3 + 1], 1'b1);
      else                  cycle(1'b0, 36'h0, 1'b1);
    end
    check("b2b_in_ready_pulses", ir_seen, 4);
    check("b2b_valid_beats", ov_seen, 12);
    #1;
    check("b2b_count", ifa.word_count, 16'd5);
    cycle(1'b0, 36'h0, 1'b1);

    // Backpressure during lane 1
    cycle(1'b1, 36'h00F_0F0_F00, 1'b1);
    cycle(1'b0, 36'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, {$urandom, $urandom}, 1'b0);
      check("bp_hold_data", ifa.out_data, 12'h0F0);
      check("bp_hold_lane", ifa.out_lane, 2'd1);
    end
    cycle(1'b0, 36'h0, 1'b1);
    #1;
    check("bp_resume_lane2", ifa.out_data, 12'h00F);
    cycle(1'b0, 36'h0, 1'b1);
    cycle(1'b0, 36'h0, 1'b1);

    // in_data changes every cycle while a word is in flight
    cycle(1'b1, 36'h876_543_210, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, {$urandom, $urandom}, 1'b1);

    // Enough back-to-back words to wrap the narrow counter at least once
    for (int i = 0; i < 60; i++) cycle(1'b1, {$urandom, $urandom}, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 36'h0, 1'b1);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom};
      cycle(1'($urandom_range(0, 1)), rnd, ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 36'h0, 1'b1);

    // Reset mid-word, right after lane 0 is accepted
    cycle(1'b1, 36'hCAF_E12_345, 1'b1);
    cycle(1'b0, 36'h0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    q.delete();
    cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 36'h321_654_987, 1'b1);
    #1;
    check("post_reset_lane", ifa.out_lane, 2'd0);
    check("post_reset_data", ifa.out_data, 12'h987);
    for (int i = 0; i < 4; i++) cycle(1'b0, 36'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
